// File: rtl/zap_thumb_fetch_unpacker_pkg.sv
// Shared types and constants for the Thumb/ARM fetch unpacker.
// Holds the T-bit encodings, PC step/offset values and buffer state encoding.
package zap_thumb_fetch_unpacker_pkg;

    localparam logic T_ARM   = 1'b0;
    localparam logic T_THUMB = 1'b1;

    localparam logic [31:0] PC_STEP_THUMB = 32'd2;
    localparam logic [31:0] PC_STEP_ARM   = 32'd4;
    localparam logic [31:0] PC_OFF_THUMB  = 32'd4;
    localparam logic [31:0] PC_OFF_ARM    = 32'd8;

    typedef enum logic [2:0] {
        ST_EMPTY = 3'b001,
        ST_LOW   = 3'b010,
        ST_HIGH  = 3'b100
    } fetch_state_t;

    // An aborted word skips whatever is left of it: resume at the next word boundary.
    function automatic logic [31:0] next_word_pc(input logic [31:0] pc);
        return {pc[31:2] + 30'd1, 2'b00};
    endfunction

endpackage

// File: rtl/zap_halfword_select.sv
// Picks the Thumb halfword to emit: from the buffered word when one is held,
// otherwise from the incoming word (high half for a misaligned branch target).
module zap_halfword_select
    import zap_thumb_fetch_unpacker_pkg::*;
(
    input  fetch_state_t state_i,
    input  logic         skip_i,
    input  logic [31:0]  buf_i,
    input  logic [31:0]  word_i,
    output logic [15:0]  half_o
);

    always_comb begin
        case (state_i)
            ST_LOW:  half_o = buf_i[15:0];
            ST_HIGH: half_o = buf_i[31:16];
            default: half_o = skip_i ? word_i[31:16] : word_i[15:0];
        endcase
    end

endmodule

// File: rtl/zap_thumb_fetch_unpacker.sv
// Turns I-cache words into one Thumb halfword or one ARM word per cycle,
// tagging each slot with its PC, PC read value, abort and interrupt state.
module zap_thumb_fetch_unpacker
    import zap_thumb_fetch_unpacker_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic [31:0] i_clear_pc,
    input  logic        i_stall,
    input  logic        i_cpsr_ff_t,
    input  logic [31:0] i_word,
    input  logic        i_word_valid,
    input  logic        i_word_abort,
    input  logic        i_irq,
    input  logic        i_fiq,
    output logic        o_word_ready,
    output logic [31:0] o_instruction,
    output logic        o_instruction_valid,
    output logic        o_iabort,
    output logic [31:0] o_pc_ff,
    output logic [31:0] o_pc_plus_8_ff,
    output logic        o_irq,
    output logic        o_fiq
);

    fetch_state_t state_q, state_d;
    logic [31:0]  buf_q;
    logic [31:0]  pc_q, pc_d;
    logic         babt_q;
    logic         skip_q, skip_d;
    logic         is_thumb, accept, emit, slot_abt;
    logic [15:0]  half;
    logic [31:0]  slot_instr;
    logic         t_prev_q, clr_prev_q;
    logic         unused_pc0;

    assign unused_pc0 = i_clear_pc[0];
    assign is_thumb   = (i_cpsr_ff_t == T_THUMB);

    // In Thumb a new word is taken only while the buffer is empty or draining its last half.
    assign o_word_ready = !i_reset && !i_clear && !i_stall &&
                          ((state_q == ST_EMPTY) ||
                           ((state_q == ST_HIGH) && is_thumb) ||
                           (i_cpsr_ff_t == T_ARM));
    assign accept = i_word_valid && o_word_ready;

    zap_halfword_select u_sel (
        .state_i (state_q),
        .skip_i  (skip_q),
        .buf_i   (buf_q),
        .word_i  (i_word),
        .half_o  (half)
    );

    always_comb begin
        emit     = accept;
        slot_abt = i_word_abort;
        state_d  = state_q;
        skip_d   = skip_q;
        if (is_thumb) begin
            case (state_q)
                ST_LOW: begin
                    emit     = 1'b1;
                    slot_abt = babt_q;
                    state_d  = babt_q ? ST_EMPTY : ST_HIGH;
                end
                ST_HIGH: begin
                    emit     = 1'b1;
                    slot_abt = babt_q;
                    state_d  = accept ? ST_LOW : ST_EMPTY;
                end
                default: begin
                    if (accept) begin
                        skip_d  = 1'b0;
                        state_d = (i_word_abort || skip_q) ? ST_EMPTY : ST_HIGH;
                    end
                end
            endcase
        end

        slot_instr = slot_abt ? 32'd0 : (is_thumb ? {16'd0, half} : i_word);

        pc_d = pc_q;
        if (emit)
            pc_d = slot_abt ? next_word_pc(pc_q)
                            : pc_q + (is_thumb ? PC_STEP_THUMB : PC_STEP_ARM);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q             <= ST_EMPTY;
            pc_q                <= '0;
            skip_q              <= 1'b0;
            babt_q              <= 1'b0;
            o_instruction       <= '0;
            o_instruction_valid <= 1'b0;
            o_iabort            <= 1'b0;
            o_pc_ff             <= '0;
            o_pc_plus_8_ff      <= '0;
            o_irq               <= 1'b0;
            o_fiq               <= 1'b0;
        end else if (i_clear) begin
            state_q             <= ST_EMPTY;
            pc_q                <= {i_clear_pc[31:1], 1'b0};
            skip_q              <= i_clear_pc[1] & is_thumb;
            o_instruction_valid <= 1'b0;
            o_iabort            <= 1'b0;
            o_irq               <= 1'b0;
            o_fiq               <= 1'b0;
        end else if (!i_stall) begin
            state_q             <= state_d;
            skip_q              <= skip_d;
            pc_q                <= pc_d;
            o_instruction_valid <= emit;
            if (accept) begin
                buf_q  <= i_word;
                babt_q <= i_word_abort;
            end
            if (emit) begin
                o_instruction  <= slot_instr;
                o_pc_ff        <= pc_q;
                o_pc_plus_8_ff <= pc_q + (is_thumb ? PC_OFF_THUMB : PC_OFF_ARM);
                o_iabort       <= slot_abt;
                o_irq          <= i_irq;
                o_fiq          <= i_fiq;
            end
        end
    end

    // The T bit may only move together with (or right after) a flush.
    always_ff @(posedge i_clk) begin
        t_prev_q   <= i_cpsr_ff_t;
        clr_prev_q <= i_clear | i_reset;
        if (!i_reset && !i_clear && !clr_prev_q)
            a_tbit_stable: assert (i_cpsr_ff_t == t_prev_q);
    end

endmodule

// File: tb/tb_zap_thumb_fetch_unpacker.sv
// Directed bench for zap_thumb_fetch_unpacker: a vector table plus hand-written
// stall, clear-under-stall and reset-mid-sequence sequences.
module tb_zap_thumb_fetch_unpacker;

    logic        i_clk;
    logic        i_reset;
    logic        i_clear;
    logic [31:0] i_clear_pc;
    logic        i_stall;
    logic        i_cpsr_ff_t;
    logic [31:0] i_word;
    logic        i_word_valid;
    logic        i_word_abort;
    logic        i_irq;
    logic        i_fiq;
    logic        o_word_ready;
    logic [31:0] o_instruction;
    logic        o_instruction_valid;
    logic        o_iabort;
    logic [31:0] o_pc_ff;
    logic [31:0] o_pc_plus_8_ff;
    logic        o_irq;
    logic        o_fiq;

    int n_cmp  = 0;
    int n_fail = 0;

    zap_thumb_fetch_unpacker dut (
        .i_clk               (i_clk),
        .i_reset             (i_reset),
        .i_clear             (i_clear),
        .i_clear_pc          (i_clear_pc),
        .i_stall             (i_stall),
        .i_cpsr_ff_t         (i_cpsr_ff_t),
        .i_word              (i_word),
        .i_word_valid        (i_word_valid),
        .i_word_abort        (i_word_abort),
        .i_irq               (i_irq),
        .i_fiq               (i_fiq),
        .o_word_ready        (o_word_ready),
        .o_instruction       (o_instruction),
        .o_instruction_valid (o_instruction_valid),
        .o_iabort            (o_iabort),
        .o_pc_ff             (o_pc_ff),
        .o_pc_plus_8_ff      (o_pc_plus_8_ff),
        .o_irq               (o_irq),
        .o_fiq               (o_fiq)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        clr;
        logic [31:0] cpc;
        logic        t;
        logic [31:0] w;
        logic        v;
        logic        a;
        logic        irq;
        logic        fiq;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_ins;
        logic [31:0] e_pc;
        logic [31:0] e_pc8;
        logic        e_iab;
        logic        e_irq;
        logic        e_fiq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t row(
        input logic clr, input logic [31:0] cpc, input logic t, input logic [31:0] w,
        input logic v, input logic a, input logic irq, input logic fiq,
        input logic rdy, input logic vld, input logic [31:0] ins, input logic [31:0] pc,
        input logic [31:0] pc8, input logic iab, input logic oirq, input logic ofiq);
        vec_t r;
        r.clr = clr;   r.cpc = cpc;   r.t = t;       r.w = w;
        r.v = v;       r.a = a;       r.irq = irq;   r.fiq = fiq;
        r.e_rdy = rdy; r.e_vld = vld; r.e_ins = ins; r.e_pc = pc;
        r.e_pc8 = pc8; r.e_iab = iab; r.e_irq = oirq; r.e_fiq = ofiq;
        return r;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_slot(input string name, input logic [31:0] ins, input logic [31:0] pc,
                              input logic [31:0] pc8, input logic iab);
        chk1 ({name, ".vld"}, o_instruction_valid, 1'b1);
        chk32({name, ".ins"}, o_instruction, ins);
        chk32({name, ".pc"},  o_pc_ff, pc);
        chk32({name, ".pc8"}, o_pc_plus_8_ff, pc8);
        chk1 ({name, ".iab"}, o_iabort, iab);
    endtask

    task automatic apply(input vec_t r, input int idx);
        i_clear      = r.clr;
        i_clear_pc   = r.cpc;
        i_cpsr_ff_t  = r.t;
        i_word       = r.w;
        i_word_valid = r.v;
        i_word_abort = r.a;
        i_irq        = r.irq;
        i_fiq        = r.fiq;
        i_stall      = 1'b0;
        #1;
        chk1($sformatf("row%0d.rdy", idx), o_word_ready, r.e_rdy);
        @(posedge i_clk);
        #1;
        chk1($sformatf("row%0d.vld", idx), o_instruction_valid, r.e_vld);
        if (r.e_vld) begin
            chk32($sformatf("row%0d.ins", idx), o_instruction, r.e_ins);
            chk32($sformatf("row%0d.pc", idx),  o_pc_ff, r.e_pc);
            chk32($sformatf("row%0d.pc8", idx), o_pc_plus_8_ff, r.e_pc8);
            chk1 ($sformatf("row%0d.iab", idx), o_iabort, r.e_iab);
            chk1 ($sformatf("row%0d.irq", idx), o_irq, r.e_irq);
            chk1 ($sformatf("row%0d.fiq", idx), o_fiq, r.e_fiq);
        end
    endtask

    task automatic drive(input logic clr, input logic [31:0] cpc, input logic stall,
                         input logic [31:0] w, input logic v);
        i_clear      = clr;
        i_clear_pc   = cpc;
        i_stall      = stall;
        i_word       = w;
        i_word_valid = v;
        i_word_abort = 1'b0;
        i_irq        = 1'b0;
        i_fiq        = 1'b0;
        i_cpsr_ff_t  = 1'b1;
    endtask

    initial begin
        i_reset = 1'b1; i_clear = 1'b0; i_clear_pc = '0; i_stall = 1'b0;
        i_cpsr_ff_t = 1'b1; i_word = '0; i_word_valid = 1'b0; i_word_abort = 1'b0;
        i_irq = 1'b0; i_fiq = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk1 ("rst.rdy",  o_word_ready, 1'b0);
        chk1 ("rst.vld",  o_instruction_valid, 1'b0);
        chk32("rst.ins",  o_instruction, 32'd0);
        chk32("rst.pc",   o_pc_ff, 32'd0);
        chk32("rst.pc8",  o_pc_plus_8_ff, 32'd0);
        chk1 ("rst.iab",  o_iabort, 1'b0);
        chk1 ("rst.irq",  o_irq, 1'b0);
        chk1 ("rst.fiq",  o_fiq, 1'b0);
        i_reset = 1'b0;

        //                 clr cpc           t  word          v  a  irq fiq  rdy vld ins           pc            pc8           iab irq fiq
        vecs.push_back(row(1, 32'h0000_0100, 1, 32'h0,         0, 0, 0, 0,   0, 0, 32'h0,         32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'hBBBB_AAAA, 1, 0, 0, 0,   1, 1, 32'h0000_AAAA, 32'h100,      32'h104,      0, 0, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'hDDDD_CCCC, 1, 0, 1, 0,   1, 1, 32'h0000_BBBB, 32'h102,      32'h106,      0, 1, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'h1234_5678, 1, 0, 0, 0,   0, 1, 32'h0000_CCCC, 32'h104,      32'h108,      0, 0, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'h0,         0, 0, 0, 0,   1, 1, 32'h0000_DDDD, 32'h106,      32'h10A,      0, 0, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'h0,         0, 0, 0, 0,   1, 0, 32'h0,         32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(row(1, 32'h0000_0202, 1, 32'h0,         0, 0, 0, 0,   0, 0, 32'h0,         32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'h2222_1111, 1, 0, 0, 1,   1, 1, 32'h0000_2222, 32'h202,      32'h206,      0, 0, 1));
        vecs.push_back(row(0, 32'h0,         1, 32'h4444_3333, 1, 0, 0, 0,   1, 1, 32'h0000_3333, 32'h204,      32'h208,      0, 0, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'h0,         0, 0, 0, 0,   1, 1, 32'h0000_4444, 32'h206,      32'h20A,      0, 0, 0));
        vecs.push_back(row(1, 32'h0000_0300, 1, 32'h0,         0, 0, 0, 0,   0, 0, 32'h0,         32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'hDEAD_BEEF, 1, 1, 0, 0,   1, 1, 32'h0,         32'h300,      32'h304,      1, 0, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'h0,         0, 0, 0, 0,   1, 0, 32'h0,         32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'h6666_5555, 1, 0, 0, 0,   1, 1, 32'h0000_5555, 32'h304,      32'h308,      0, 0, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'h0,         0, 0, 0, 0,   1, 1, 32'h0000_6666, 32'h306,      32'h30A,      0, 0, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'h8888_7777, 1, 0, 0, 0,   1, 1, 32'h0000_7777, 32'h308,      32'h30C,      0, 0, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'hCAFE_F00D, 1, 1, 0, 0,   1, 1, 32'h0000_8888, 32'h30A,      32'h30E,      0, 0, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'h0,         0, 0, 0, 0,   0, 1, 32'h0,         32'h30C,      32'h310,      1, 0, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'h0,         0, 0, 0, 0,   1, 0, 32'h0,         32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'hAAAA_9999, 1, 0, 0, 0,   1, 1, 32'h0000_9999, 32'h310,      32'h314,      0, 0, 0));
        vecs.push_back(row(1, 32'h0000_0400, 1, 32'h1111_2222, 1, 0, 0, 0,   0, 0, 32'h0,         32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'hBBBB_CCCC, 1, 0, 0, 0,   1, 1, 32'h0000_CCCC, 32'h400,      32'h404,      0, 0, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'h0,         0, 0, 0, 0,   1, 1, 32'h0000_BBBB, 32'h402,      32'h406,      0, 0, 0));
        vecs.push_back(row(1, 32'h0000_8000, 0, 32'h0,         0, 0, 0, 0,   0, 0, 32'h0,         32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(row(0, 32'h0,         0, 32'hE3A0_0001, 1, 0, 0, 0,   1, 1, 32'hE3A0_0001, 32'h8000,     32'h8008,     0, 0, 0));
        vecs.push_back(row(0, 32'h0,         0, 32'hE281_1002, 1, 0, 1, 1,   1, 1, 32'hE281_1002, 32'h8004,     32'h800C,     0, 1, 1));
        vecs.push_back(row(0, 32'h0,         0, 32'h0,         0, 0, 0, 0,   1, 0, 32'h0,         32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(row(0, 32'h0,         0, 32'h1234_5678, 1, 1, 0, 0,   1, 1, 32'h0,         32'h8008,     32'h8010,     1, 0, 0));
        vecs.push_back(row(0, 32'h0,         0, 32'h9ABC_DEF0, 1, 0, 0, 0,   1, 1, 32'h9ABC_DEF0, 32'h800C,     32'h8014,     0, 0, 0));
        vecs.push_back(row(1, 32'hFFFF_FFFF, 1, 32'h0,         0, 0, 0, 0,   0, 0, 32'h0,         32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'h5555_6666, 1, 0, 0, 0,   1, 1, 32'h0000_5555, 32'hFFFF_FFFE, 32'h0000_0002, 0, 0, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'h7777_8888, 1, 0, 0, 0,   1, 1, 32'h0000_8888, 32'h0,        32'h4,        0, 0, 0));
        vecs.push_back(row(0, 32'h0,         1, 32'h0,         0, 0, 0, 0,   1, 1, 32'h0000_7777, 32'h2,        32'h6,        0, 0, 0));

        foreach (vecs[i]) apply(vecs[i], i);

        // Stall while the high half is pending: outputs frozen, high half emitted exactly once.
        drive(1, 32'h600, 0, 32'h0, 0); tick();
        chk1("stl.clr.vld", o_instruction_valid, 1'b0);
        drive(0, 32'h0, 0, 32'h0F0E_0D0C, 1); tick();
        check_slot("stl.low", 32'h0000_0D0C, 32'h600, 32'h604, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 32'h0, 1, 32'hFFFF_0000, 1);
            #1;
            chk1($sformatf("stl%0d.rdy", k), o_word_ready, 1'b0);
            tick();
            check_slot($sformatf("stl%0d.hold", k), 32'h0000_0D0C, 32'h600, 32'h604, 1'b0);
        end
        drive(0, 32'h0, 0, 32'h0, 0); tick();
        check_slot("stl.high", 32'h0000_0F0E, 32'h602, 32'h606, 1'b0);
        drive(0, 32'h0, 0, 32'h0, 0); tick();
        chk1("stl.nodup.vld", o_instruction_valid, 1'b0);

        // Clear arriving during a stall wins and discards the pending high half.
        drive(0, 32'h0, 0, 32'h2143_6587, 1); tick();
        check_slot("cs.low", 32'h0000_6587, 32'h604, 32'h608, 1'b0);
        drive(1, 32'h680, 1, 32'h0, 0);
        #1;
        chk1("cs.rdy", o_word_ready, 1'b0);
        tick();
        chk1("cs.vld", o_instruction_valid, 1'b0);
        drive(0, 32'h0, 0, 32'hAAAA_BBBB, 1); tick();
        check_slot("cs.first", 32'h0000_BBBB, 32'h680, 32'h684, 1'b0);
        drive(0, 32'h0, 0, 32'h0, 0); tick();
        check_slot("cs.second", 32'h0000_AAAA, 32'h682, 32'h686, 1'b0);

        // Reset with a half buffered: it must not reappear afterwards.
        drive(0, 32'h0, 0, 32'h1357_2468, 1); tick();
        check_slot("rm.low", 32'h0000_2468, 32'h684, 32'h688, 1'b0);
        drive(0, 32'h0, 0, 32'h0, 0);
        i_reset = 1'b1;
        tick();
        chk1 ("rm.rst.vld", o_instruction_valid, 1'b0);
        chk32("rm.rst.ins", o_instruction, 32'd0);
        chk32("rm.rst.pc",  o_pc_ff, 32'd0);
        chk32("rm.rst.pc8", o_pc_plus_8_ff, 32'd0);
        i_reset = 1'b0;
        #1;
        chk1("rm.rdy", o_word_ready, 1'b1);
        tick();
        chk1("rm.idle.vld", o_instruction_valid, 1'b0);
        drive(0, 32'h0, 0, 32'h9753_ECA8, 1); tick();
        check_slot("rm.new.low", 32'h0000_ECA8, 32'h0, 32'h4, 1'b0);
        drive(0, 32'h0, 0, 32'h0, 0); tick();
        check_slot("rm.new.high", 32'h0000_9753, 32'h2, 32'h6, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/zap_thumb_fetch_unpacker.md
# zap_thumb_fetch_unpacker

Fetch-side producer for the compressed-instruction decode stage. It accepts 32-bit words from the I-cache and emits one 16-bit Thumb halfword per cycle, or one 32-bit word per cycle in ARM state. Each output carries its own PC, PC-plus-pipeline-offset, abort and interrupt qualifiers. It sits between the I-cache return path and the Thumb decoder, and owns halfword sequencing, misaligned branch targets, and stall and flush handling.

## Interface
Parameters:
- none.

Ports (clock and reset first):
- `i_clk`  in  1  core clock.
- `i_reset`  in  1  reset; synchronous, active-high.
- `i_clear`  in  1  flush (branch, exception, writeback clear); restart fetch at `i_clear_pc`.
- `i_clear_pc`  in  32  restart address; bit 0 is ignored.
- `i_stall`  in  1  downstream stall; hold all outputs.
- `i_cpsr_ff_t`  in  1  T bit; 1 = Thumb, 0 = ARM.
- `i_word`  in  32  fetched word, little-endian: `[15:0]` is the lower address.
- `i_word_valid`  in  1  `i_word` qualifier.
- `i_word_abort`  in  1  instruction abort for this word.
- `i_irq`, `i_fiq`  in  1 each  level-sensitive interrupt requests.
- `o_word_ready`  out  1  combinational; a word is accepted in a cycle with `i_word_valid & o_word_ready`.
- `o_instruction`  out  32  Thumb: `{16'd0, halfword}`; ARM: full word.
- `o_instruction_valid`  out  1  output qualifier.
- `o_iabort`  out  1  the emitted slot came from an aborted word.
- `o_pc_ff`  out  32  address of the emitted instruction.
- `o_pc_plus_8_ff`  out  32  PC as read by the instruction: `o_pc_ff`+4 in Thumb, +8 in ARM.
- `o_irq`, `o_fiq`  out  1 each  sampled interrupts attached to the emitted slot.

## Operation
- State machine, one-hot:
  - `EMPTY`: no buffered word.
  - `LOW`: buffer holds a word; emit bits `[15:0]` next.
  - `HIGH`: emit bits `[31:16]` next.
- Internal registers: 32-bit word buffer `buf`, abort flag `babt`, fetch PC `pc`.
- Priority, evaluated each rising edge: `i_reset` > `i_clear` > `i_stall` > normal.
- **Reset:**
  - All outputs and `pc` go to 0; state goes to `EMPTY`.
  - `o_instruction_valid`, `o_iabort`, `o_irq` and `o_fiq` are 0.
- **Clear:**
  - `pc` ← `{i_clear_pc[31:1], 1'b0}`; state ← `EMPTY`.
  - `o_instruction_valid`, `o_iabort`, `o_irq` and `o_fiq` ← 0.
  - A skip flag is set to `i_clear_pc[1] & i_cpsr_ff_t`.
  - Any word presented in the same cycle is not accepted.
- **Stall:** all registers hold; `o_word_ready` = 0.
- **`o_word_ready`** = `!i_reset & !i_clear & !i_stall & (EMPTY | (HIGH & T) | !T)`.
- **Accept in Thumb:**
  - Load `buf` and `babt`.
  - If the skip flag is set, emit the high half this cycle and clear the skip flag; the next state is `EMPTY`.
  - Otherwise emit the low half, then go to `HIGH`.
- **Emit** drives the output registers: `o_instruction`, `o_pc_ff` = `pc`, `o_pc_plus_8_ff`, `o_iabort` = abort, `o_irq`/`o_fiq` = inputs sampled this cycle, `o_instruction_valid` = 1. Then `pc` += 2.
- **In `HIGH`:**
  - Emit `buf[31:16]`.
  - If a new word is accepted in the same cycle, load it and stay in `HIGH` after emitting its low half in the following cycle, i.e. the transition is `HIGH` → `LOW` (new word) → `HIGH`.
  - If no new word is accepted, go to `EMPTY`.
- **ARM state:** each accepted word is emitted whole in one cycle; `pc` += 4; state stays `EMPTY`.
- **No valid word and nothing buffered:** `o_instruction_valid` ← 0; the other outputs hold.
- **Abort:**
  - An aborted word produces exactly one slot with `o_iabort` = 1 and `o_instruction` = 0.
  - Its second halfword is discarded; the state goes to `EMPTY` and the buffer is not used.
- **T bit change:** only occurs with a clear. Behaviour is undefined otherwise, and this must be flagged by an assertion.
- **Address arithmetic:** 32-bit and wraps modulo 2^32; `0xFFFF_FFFE` + 2 = 0.

## Timing
- Latency: a word accepted in cycle N emits its first slot with outputs valid in cycle N+1. The second Thumb halfword is valid in N+2 unless a stall intervenes.
- Throughput: one halfword per cycle in Thumb with back-to-back words (50% word acceptance); one word per cycle in ARM.
- Stall: outputs held stable for the whole stall; no slot is lost or duplicated.
- Clear during a stall: the clear wins, and valid drops at the next edge.
- Clear and `i_word_valid` in the same cycle: the word is dropped; the first post-clear word is accepted no earlier than the cycle after the clear.
- Reset mid-sequence: the buffered halfword is discarded.

## Structure
- T-bit state encodings and the Thumb/ARM PC offsets (2/4, 4/8) go in the shared localparams include.
- One natural sub-module: `zap_halfword_select`, a combinational mux of `buf`/`i_word` by state and skip flag. Everything else is the single sequential block.

## Test plan
- **Thumb sequential:** clear to `0x100`, T=1, words `0xBBBB_AAAA`, `0xDDDD_CCCC` → slots `AAAA`@`0x100`, `BBBB`@`0x102`, `CCCC`@`0x104`, `DDDD`@`0x106`; `o_pc_plus_8_ff` = PC+4.
- **Misaligned target:** clear to `0x202`, word `0x2222_1111` → single slot `2222`@`0x202`, then next word low half @`0x204`.
- **ARM mode:** T=0, clear to `0x8000`, words `W0` and `W1` → slots `W0`@`0x8000` (`pc_plus_8` = `0x8008`) and `W1`@`0x8004`, one per cycle.
- **Stall in `HIGH`:** hold `i_stall` for 3 cycles after the low slot → `o_instruction`/`o_pc_ff` are unchanged for 3 cycles, then the high slot appears once.
- **Abort:** word with `i_word_abort`=1 @`0x300` → one slot with `o_iabort`=1 and `o_instruction`=0; the next word is emitted @`0x304`.
- **Clear collision:** `i_clear` to `0x400` with `i_word_valid` high and `HIGH` pending → `o_word_ready`=0, valid=0 next cycle, and the next accepted word emits @`0x400`.
